// File: rtl/cook_sequencer_pkg.sv
// Shared types and constants for the microwave cook-time sequencer.
//   state_e : front-panel FSM states (3-bit encoding, fixed values)
//   BcdW    : width of one BCD display digit
//   bcd_t   : one BCD digit
package cook_sequencer_pkg;

  localparam int unsigned BcdW = 4;

  typedef logic [BcdW-1:0] bcd_t;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StSet   = 3'd1,
    StRun   = 3'd2,
    StPause = 3'd3,
    StDone  = 3'd4
  } state_e;

endpackage

// File: rtl/bcd_mmss_dec.sv
// Combinational MM:SS decrement by one second, digit-wise in BCD.
//   min_tens_i .. sec_ones_i : current time digits
//   min_tens_o .. sec_ones_o : time minus one second
//   zero_o                   : decremented time is 00:00
// Seconds borrow from 00 to 59; a seconds-tens digit of 6-9 entered from the
// keypad simply counts down like any other digit.
module bcd_mmss_dec
  import cook_sequencer_pkg::*;
(
  input  bcd_t min_tens_i,
  input  bcd_t min_ones_i,
  input  bcd_t sec_tens_i,
  input  bcd_t sec_ones_i,
  output bcd_t min_tens_o,
  output bcd_t min_ones_o,
  output bcd_t sec_tens_o,
  output bcd_t sec_ones_o,
  output logic zero_o
);

  logic borrow_so, borrow_st, borrow_mo;

  always_comb begin
    borrow_so  = 1'b0;
    borrow_st  = 1'b0;
    borrow_mo  = 1'b0;
    sec_ones_o = sec_ones_i;
    sec_tens_o = sec_tens_i;
    min_ones_o = min_ones_i;
    min_tens_o = min_tens_i;

    if (sec_ones_i == '0) begin
      sec_ones_o = 4'd9;
      borrow_so  = 1'b1;
    end else begin
      sec_ones_o = sec_ones_i - 4'd1;
    end

    if (borrow_so) begin
      if (sec_tens_i == '0) begin
        sec_tens_o = 4'd5;
        borrow_st  = 1'b1;
      end else begin
        sec_tens_o = sec_tens_i - 4'd1;
      end
    end

    if (borrow_st) begin
      if (min_ones_i == '0) begin
        min_ones_o = 4'd9;
        borrow_mo  = 1'b1;
      end else begin
        min_ones_o = min_ones_i - 4'd1;
      end
    end

    // Never reached from 00:00 because the sequencer only counts non-zero times.
    if (borrow_mo) begin
      min_tens_o = min_tens_i - 4'd1;
    end

    zero_o = (min_tens_o == '0) && (min_ones_o == '0) &&
             (sec_tens_o == '0) && (sec_ones_o == '0);
  end

endmodule

// File: rtl/cook_sequencer.sv
// Microwave front-panel sequencer: keypad entry of an MM:SS cook time, one-second
// countdown while cooking, magnetron enable and door interlock.
//   clk, rstn        : clock, asynchronous active-low reset
//   startn/stopn/clearn : active-low button levels, acted on at their falling edge
//   door_closed      : interlock, 1 = closed
//   key_valid/key_digit : keypad strobe and BCD digit (10-15 ignored)
//   mag              : magnetron enable (RUN only)
//   timer_done       : one-cycle pulse when the countdown reaches 00:00
//   min_tens..sec_ones : BCD display digits
//   busy             : RUN or PAUSE
// All outputs are registers updated on the edge that samples the causing input.
module cook_sequencer
  import cook_sequencer_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 100_000_000
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            startn,
  input  logic            stopn,
  input  logic            clearn,
  input  logic            door_closed,
  input  logic            key_valid,
  input  logic [BcdW-1:0] key_digit,
  output logic            mag,
  output logic            timer_done,
  output logic [BcdW-1:0] min_tens,
  output logic [BcdW-1:0] min_ones,
  output logic [BcdW-1:0] sec_tens,
  output logic [BcdW-1:0] sec_ones,
  output logic            busy
);

  localparam int unsigned PresW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PresW-1:0] PresTerm = PresW'(TICKS_PER_SEC - 1);

  state_e            state_q, state_d;
  bcd_t              mt_q, mo_q, st_q, so_q;
  bcd_t              mt_d, mo_d, st_d, so_d;
  bcd_t              dec_mt, dec_mo, dec_st, dec_so;
  logic              dec_zero;
  logic [PresW-1:0]  presc_q, presc_d;
  logic              start_h_q, stop_h_q, clear_h_q;
  logic              mag_q, done_q, done_d, busy_q;
  logic              start_ev, stop_ev, clear_ev, key_ok, tick, time_nz;

  bcd_mmss_dec u_dec (
    .min_tens_i (mt_q),
    .min_ones_i (mo_q),
    .sec_tens_i (st_q),
    .sec_ones_i (so_q),
    .min_tens_o (dec_mt),
    .min_ones_o (dec_mo),
    .sec_tens_o (dec_st),
    .sec_ones_o (dec_so),
    .zero_o     (dec_zero)
  );

  assign start_ev = start_h_q & ~startn;
  assign stop_ev  = stop_h_q & ~stopn;
  assign clear_ev = clear_h_q & ~clearn;
  assign key_ok   = key_valid && (key_digit <= 4'd9);
  assign tick     = (presc_q == PresTerm);
  assign time_nz  = |{mt_q, mo_q, st_q, so_q};

  always_comb begin
    state_d = state_q;
    mt_d    = mt_q;
    mo_d    = mo_q;
    st_d    = st_q;
    so_d    = so_q;
    presc_d = presc_q;
    done_d  = 1'b0;

    case (state_q)
      StIdle: begin
        if (!clear_ev && key_ok) begin
          state_d = StSet;
          mt_d    = mo_q;
          mo_d    = st_q;
          st_d    = so_q;
          so_d    = key_digit;
        end
      end

      StSet: begin
        if (clear_ev) begin
          state_d = StIdle;
          {mt_d, mo_d, st_d, so_d} = '0;
        end else if (stop_ev) begin
          // Stop outranks start and key entry but has nothing to act on here.
        end else if (start_ev && door_closed && time_nz) begin
          state_d = StRun;
          presc_d = '0;
        end else if (key_ok) begin
          mt_d = mo_q;
          mo_d = st_q;
          st_d = so_q;
          so_d = key_digit;
        end
      end

      StRun: begin
        // Pausing also suppresses a coinciding tick, so the partial second is kept.
        if (stop_ev || !door_closed) begin
          state_d = StPause;
        end else if (tick) begin
          presc_d = '0;
          mt_d    = dec_mt;
          mo_d    = dec_mo;
          st_d    = dec_st;
          so_d    = dec_so;
          if (dec_zero) begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end else begin
          presc_d = presc_q + PresW'(1);
        end
      end

      StPause: begin
        if (clear_ev) begin
          state_d = StIdle;
          presc_d = '0;
          {mt_d, mo_d, st_d, so_d} = '0;
        end else if (!stop_ev && start_ev && door_closed) begin
          state_d = StRun;
        end
      end

      StDone: begin
        if (clear_ev || !door_closed) begin
          state_d = StIdle;
          presc_d = '0;
        end
      end

      default: begin
        state_d = StIdle;
        presc_d = '0;
        {mt_d, mo_d, st_d, so_d} = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      mt_q      <= '0;
      mo_q      <= '0;
      st_q      <= '0;
      so_q      <= '0;
      presc_q   <= '0;
      start_h_q <= 1'b1;
      stop_h_q  <= 1'b1;
      clear_h_q <= 1'b1;
      mag_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mt_q      <= mt_d;
      mo_q      <= mo_d;
      st_q      <= st_d;
      so_q      <= so_d;
      presc_q   <= presc_d;
      start_h_q <= startn;
      stop_h_q  <= stopn;
      clear_h_q <= clearn;
      mag_q     <= (state_d == StRun);
      done_q    <= done_d;
      busy_q    <= (state_d == StRun) || (state_d == StPause);
    end
  end

  assign mag        = mag_q;
  assign timer_done = done_q;
  assign busy       = busy_q;
  assign min_tens   = mt_q;
  assign min_ones   = mo_q;
  assign sec_tens   = st_q;
  assign sec_ones   = so_q;

endmodule

// File: tb/tb_cook_sequencer.sv
module tb_cook_sequencer;

  logic       clk = 1'b0;
  logic       rstn;
  logic       startn, stopn, clearn, door_closed, key_valid;
  logic [3:0] key_digit;
  logic       mag, timer_done, busy;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;

  cook_sequencer #(
    .TICKS_PER_SEC (4)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .startn      (startn),
    .stopn       (stopn),
    .clearn      (clearn),
    .door_closed (door_closed),
    .key_valid   (key_valid),
    .key_digit   (key_digit),
    .mag         (mag),
    .timer_done  (timer_done),
    .min_tens    (min_tens),
    .min_ones    (min_ones),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        mag;
    logic        done;
    logic        busy;
    logic [15:0] tm;
  } out_t;

  typedef struct packed {
    logic       st;
    logic       sp;
    logic       cl;
    logic       dr;
    logic       kv;
    logic [3:0] kd;
    out_t       exp;
  } vec_t;

  vec_t vecs[$];
  out_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic vec_t mk(logic st, logic sp, logic cl, logic dr, logic kv, logic [3:0] kd,
                              logic m, logic d, logic b, logic [15:0] tm);
    vec_t v;
    v.st  = st;
    v.sp  = sp;
    v.cl  = cl;
    v.dr  = dr;
    v.kv  = kv;
    v.kd  = kd;
    v.exp = '{mag: m, done: d, busy: b, tm: tm};
    return v;
  endfunction

  // No button, door closed, no key.
  function automatic vec_t nop(logic m, logic d, logic b, logic [15:0] tm);
    return mk(1, 1, 1, 1, 0, 4'd0, m, d, b, tm);
  endfunction

  // Key press while not cooking.
  function automatic vec_t key(logic [3:0] k, logic [15:0] tm);
    return mk(1, 1, 1, 1, 1, k, 0, 0, 0, tm);
  endfunction

  function automatic out_t sample();
    out_t o;
    o.mag  = mag;
    o.done = timer_done;
    o.busy = busy;
    o.tm   = {min_tens, min_ones, sec_tens, sec_ones};
    return o;
  endfunction

  task automatic check(input string nm, input out_t got, input out_t want);
    n_checks++;
    if (got === want) n_pass++;
    else
      $display("FAIL %s: got mag=%0b done=%0b busy=%0b time=%h, want mag=%0b done=%0b busy=%0b time=%h",
               nm, got.mag, got.done, got.busy, got.tm, want.mag, want.done, want.busy, want.tm);
  endtask

  task automatic apply(input vec_t v, input string nm);
    startn      = v.st;
    stopn       = v.sp;
    clearn      = v.cl;
    door_closed = v.dr;
    key_valid   = v.kv;
    key_digit   = v.kd;
    exp_q.push_back(v.exp);
    @(posedge clk);
    #1;
    check(nm, sample(), exp_q.pop_front());
  endtask

  // Run a time whose first decrement is known: start, three prescaler cycles, tick, then pause+clear.
  task automatic add_first_dec(input logic [15:0] t0, input logic [15:0] t1);
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 1, 0, 1, t0));
    for (int i = 0; i < 3; i++) vecs.push_back(nop(1, 0, 1, t0));
    vecs.push_back(nop(1, 0, 1, t1));
    vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0, 1, t1));
    vecs.push_back(nop(0, 0, 1, t1));
    vecs.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 16'h0000));
    vecs.push_back(nop(0, 0, 0, 16'h0000));
  endtask

  initial begin
    rstn = 1'b0;
    startn = 1'b1; stopn = 1'b1; clearn = 1'b1; door_closed = 1'b1;
    key_valid = 1'b0; key_digit = 4'd0;
    #12;
    check("reset_state", sample(), '{mag: 0, done: 0, busy: 0, tm: 16'h0000});
    @(negedge clk);
    rstn = 1'b1;

    // 00:03 full countdown to DONE; timer_done 12 cycles after the start edge.
    vecs.push_back(key(0, 16'h0000));
    vecs.push_back(key(0, 16'h0000));
    vecs.push_back(key(0, 16'h0000));
    vecs.push_back(key(3, 16'h0003));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 1, 0, 1, 16'h0003));
    for (int i = 1; i <= 11; i++) vecs.push_back(nop(1, 0, 1, 16'(3 - i / 4)));
    vecs.push_back(nop(0, 1, 0, 16'h0000));
    vecs.push_back(nop(0, 0, 0, 16'h0000));
    vecs.push_back(key(5, 16'h0000));                               // DONE ignores keys
    vecs.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 16'h0000));
    vecs.push_back(nop(0, 0, 0, 16'h0000));

    // 01:00 -> 00:59 -> 00:58 (minute borrow).
    vecs.push_back(key(1, 16'h0001));
    vecs.push_back(key(0, 16'h0010));
    vecs.push_back(key(0, 16'h0100));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 1, 0, 1, 16'h0100));
    for (int i = 1; i <= 8; i++)
      vecs.push_back(nop(1, 0, 1, (i < 4) ? 16'h0100 : (i < 8) ? 16'h0059 : 16'h0058));
    vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0, 1, 16'h0058));
    vecs.push_back(nop(0, 0, 1, 16'h0058));
    vecs.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 16'h0000));
    vecs.push_back(nop(0, 0, 0, 16'h0000));

    // 00:90 -> 00:89 and 10:00 -> 09:59.
    vecs.push_back(key(9, 16'h0009));
    vecs.push_back(key(0, 16'h0090));
    add_first_dec(16'h0090, 16'h0089);
    vecs.push_back(key(1, 16'h0001));
    vecs.push_back(key(0, 16'h0010));
    vecs.push_back(key(0, 16'h0100));
    vecs.push_back(key(0, 16'h1000));
    add_first_dec(16'h1000, 16'h0959);

    // Door opens in RUN at 00:05; resume keeps the partial second.
    vecs.push_back(key(5, 16'h0005));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 1, 0, 1, 16'h0005));
    vecs.push_back(nop(1, 0, 1, 16'h0005));
    vecs.push_back(nop(1, 0, 1, 16'h0005));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 1, 16'h0005));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 1, 16'h0005));
    vecs.push_back(nop(0, 0, 1, 16'h0005));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 1, 0, 1, 16'h0005));
    vecs.push_back(nop(1, 0, 1, 16'h0005));
    vecs.push_back(nop(1, 0, 1, 16'h0004));
    vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0, 1, 16'h0004));
    vecs.push_back(nop(0, 0, 1, 16'h0004));
    vecs.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 16'h0000));
    vecs.push_back(nop(0, 0, 0, 16'h0000));

    // Start with door open in SET, clear, start at 00:00 in IDLE and SET.
    vecs.push_back(key(0, 16'h0000));
    vecs.push_back(key(7, 16'h0007));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 16'h0007));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 16'h0007));
    vecs.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 16'h0000));
    vecs.push_back(nop(0, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 16'h0000));
    vecs.push_back(nop(0, 0, 0, 16'h0000));
    vecs.push_back(key(0, 16'h0000));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 16'h0000));
    vecs.push_back(nop(0, 0, 0, 16'h0000));
    vecs.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 16'h0000));
    vecs.push_back(nop(0, 0, 0, 16'h0000));

    // Stop and start together -> PAUSE; held start never repeats.
    vecs.push_back(key(9, 16'h0009));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 1, 0, 1, 16'h0009));
    vecs.push_back(nop(1, 0, 1, 16'h0009));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 1, 16'h0009));
    for (int i = 0; i < 10; i++) vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 1, 16'h0009));
    vecs.push_back(nop(0, 0, 1, 16'h0009));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 1, 0, 1, 16'h0009));
    vecs.push_back(nop(1, 0, 1, 16'h0009));
    vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0, 1, 16'h0009));
    vecs.push_back(nop(0, 0, 1, 16'h0009));
    vecs.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 16'h0000));
    vecs.push_back(nop(0, 0, 0, 16'h0000));

    // Stop on the final tick: PAUSE at 00:01, no timer_done; resume finishes at once.
    vecs.push_back(key(1, 16'h0001));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 1, 0, 1, 16'h0001));
    for (int i = 0; i < 3; i++) vecs.push_back(nop(1, 0, 1, 16'h0001));
    vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0, 1, 16'h0001));
    vecs.push_back(nop(0, 0, 1, 16'h0001));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 1, 0, 1, 16'h0001));
    vecs.push_back(nop(0, 1, 0, 16'h0000));
    vecs.push_back(nop(0, 0, 0, 16'h0000));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 16'h0000));       // door open leaves DONE
    vecs.push_back(nop(0, 0, 0, 16'h0000));

    // Five keys -> 23:45, invalid digit ignored, then into RUN.
    vecs.push_back(key(1, 16'h0001));
    vecs.push_back(key(2, 16'h0012));
    vecs.push_back(key(3, 16'h0123));
    vecs.push_back(key(4, 16'h1234));
    vecs.push_back(key(5, 16'h2345));
    vecs.push_back(key(12, 16'h2345));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 1, 0, 1, 16'h2345));
    vecs.push_back(nop(1, 0, 1, 16'h2345));
    vecs.push_back(nop(1, 0, 1, 16'h2345));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Asynchronous reset mid-RUN: outputs clear without waiting for a clock edge.
    #2;
    rstn = 1'b0;
    #1;
    check("async_reset", sample(), '{mag: 0, done: 0, busy: 0, tm: 16'h0000});
    @(negedge clk);
    rstn = 1'b1;
    apply(nop(0, 0, 0, 16'h0000), "post_reset_idle");
    apply(key(4, 16'h0004), "post_reset_key");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
